// File: rtl/alu_reservation_station_if.sv
// ---------------------------------------------------------------------------
// alu_reservation_station_if
//   Groups the dispatch, CDB-snoop and issue buses of the ALU reservation
//   station. The master side (dispatch stage / result buses / ALU) drives
//   dispatch and CDB signals. The slave side (the reservation station)
//   drives full and the issue bus.
//
//   Dispatch : disp_valid, disp_type, disp_vj, disp_vk, disp_qj_busy,
//              disp_qj, disp_qk_busy, disp_qk, disp_rob_id, full
//   ALU CDB  : alu_cdb_ready, alu_cdb_rob, alu_cdb_val
//   LSB CDB  : lsb_cdb_ready, lsb_cdb_rob, lsb_cdb_val
//   Issue    : alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
// ---------------------------------------------------------------------------
interface alu_reservation_station_if #(
    parameter int TYPE_BIT      = 4,
    parameter int ROB_INDEX_BIT = 4
);
    logic                     disp_valid;
    logic [TYPE_BIT-1:0]      disp_type;
    logic [31:0]              disp_vj;
    logic [31:0]              disp_vk;
    logic                     disp_qj_busy;
    logic [ROB_INDEX_BIT-1:0] disp_qj;
    logic                     disp_qk_busy;
    logic [ROB_INDEX_BIT-1:0] disp_qk;
    logic [ROB_INDEX_BIT-1:0] disp_rob_id;

    logic                     alu_cdb_ready;
    logic [ROB_INDEX_BIT-1:0] alu_cdb_rob;
    logic [31:0]              alu_cdb_val;
    logic                     lsb_cdb_ready;
    logic [ROB_INDEX_BIT-1:0] lsb_cdb_rob;
    logic [31:0]              lsb_cdb_val;

    logic                     full;
    logic                     alu_req;
    logic [TYPE_BIT-1:0]      alu_type;
    logic [31:0]              alu_r1;
    logic [31:0]              alu_r2;
    logic [ROB_INDEX_BIT-1:0] alu_rob_id;

    modport master (
        output disp_valid, disp_type, disp_vj, disp_vk, disp_qj_busy, disp_qj,
               disp_qk_busy, disp_qk, disp_rob_id,
               alu_cdb_ready, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_ready, lsb_cdb_rob, lsb_cdb_val,
        input  full, alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
    );

    modport slave (
        input  disp_valid, disp_type, disp_vj, disp_vk, disp_qj_busy, disp_qj,
               disp_qk_busy, disp_qk, disp_rob_id,
               alu_cdb_ready, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_ready, lsb_cdb_rob, lsb_cdb_val,
        output full, alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//   Holds dispatched ALU/branch/JALR ops until both operands are known, then
//   issues at most one per cycle to the ALU. Operand tags are resolved by
//   snooping the ALU and LSB result buses; a flush empties the station.
//
//   clk_in  : clock, all state on posedge
//   rst_in  : synchronous reset, active low
//   rdy_in  : global ready; low freezes all state and outputs
//   flush   : ROB mispredict clear
//   bus     : dispatch / CDB inputs, full and issue outputs (slave modport)
// ---------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int RS_SIZE_BIT   = 3,
    parameter int TYPE_BIT      = 4,
    parameter int ROB_INDEX_BIT = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush,
    alu_reservation_station_if.slave      bus
);
    localparam int RS_SIZE = 1 << RS_SIZE_BIT;

    // Entry storage
    logic [RS_SIZE-1:0]       r_valid;
    logic [RS_SIZE-1:0]       r_qj_busy;
    logic [RS_SIZE-1:0]       r_qk_busy;
    logic [TYPE_BIT-1:0]      r_type  [RS_SIZE];
    logic [31:0]              r_vj    [RS_SIZE];
    logic [31:0]              r_vk    [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] r_qj    [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] r_qk    [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] r_rob   [RS_SIZE];

    // Issue output registers
    logic                     r_alu_req;
    logic [TYPE_BIT-1:0]      r_alu_type;
    logic [31:0]              r_alu_r1;
    logic [31:0]              r_alu_r2;
    logic [ROB_INDEX_BIT-1:0] r_alu_rob_id;

    logic                     w_full;
    logic                     w_free_found;
    logic [RS_SIZE_BIT-1:0]   w_free_idx;
    logic                     w_issue_found;
    logic [RS_SIZE_BIT-1:0]   w_issue_idx;
    logic                     w_dj_busy;
    logic [31:0]              w_dj_val;
    logic                     w_dk_busy;
    logic [31:0]              w_dk_val;

    assign w_full = &r_valid;

    // Lowest free slot and lowest ready slot, both from pre-edge state, so a
    // slot vacated by this cycle's issue is never reused in the same cycle.
    always_comb begin
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_issue_found = 1'b0;
        w_issue_idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!w_free_found && !r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = RS_SIZE_BIT'(i);
            end
            if (!w_issue_found && r_valid[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
                w_issue_found = 1'b1;
                w_issue_idx   = RS_SIZE_BIT'(i);
            end
        end
    end

    // Same-cycle forwarding for the op being dispatched; ALU bus has priority.
    always_comb begin
        w_dj_busy = bus.disp_qj_busy;
        w_dj_val  = bus.disp_vj;
        if (bus.disp_qj_busy) begin
            if (bus.alu_cdb_ready && bus.alu_cdb_rob == bus.disp_qj) begin
                w_dj_busy = 1'b0;
                w_dj_val  = bus.alu_cdb_val;
            end else if (bus.lsb_cdb_ready && bus.lsb_cdb_rob == bus.disp_qj) begin
                w_dj_busy = 1'b0;
                w_dj_val  = bus.lsb_cdb_val;
            end
        end
        w_dk_busy = bus.disp_qk_busy;
        w_dk_val  = bus.disp_vk;
        if (bus.disp_qk_busy) begin
            if (bus.alu_cdb_ready && bus.alu_cdb_rob == bus.disp_qk) begin
                w_dk_busy = 1'b0;
                w_dk_val  = bus.alu_cdb_val;
            end else if (bus.lsb_cdb_ready && bus.lsb_cdb_rob == bus.disp_qk) begin
                w_dk_busy = 1'b0;
                w_dk_val  = bus.lsb_cdb_val;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_valid      <= '0;
            r_alu_req    <= 1'b0;
            r_alu_type   <= '0;
            r_alu_r1     <= '0;
            r_alu_r2     <= '0;
            r_alu_rob_id <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_valid   <= '0;
                r_alu_req <= 1'b0;
            end else begin
                // Wakeup: only valid entries snoop; the issuing entry is
                // already operand-complete so it is never touched here.
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (r_valid[i] && r_qj_busy[i]) begin
                        if (bus.alu_cdb_ready && bus.alu_cdb_rob == r_qj[i]) begin
                            r_vj[i]      <= bus.alu_cdb_val;
                            r_qj_busy[i] <= 1'b0;
                        end else if (bus.lsb_cdb_ready && bus.lsb_cdb_rob == r_qj[i]) begin
                            r_vj[i]      <= bus.lsb_cdb_val;
                            r_qj_busy[i] <= 1'b0;
                        end
                    end
                    if (r_valid[i] && r_qk_busy[i]) begin
                        if (bus.alu_cdb_ready && bus.alu_cdb_rob == r_qk[i]) begin
                            r_vk[i]      <= bus.alu_cdb_val;
                            r_qk_busy[i] <= 1'b0;
                        end else if (bus.lsb_cdb_ready && bus.lsb_cdb_rob == r_qk[i]) begin
                            r_vk[i]      <= bus.lsb_cdb_val;
                            r_qk_busy[i] <= 1'b0;
                        end
                    end
                end

                if (w_issue_found) begin
                    r_valid[w_issue_idx] <= 1'b0;
                    r_alu_req            <= 1'b1;
                    r_alu_type           <= r_type[w_issue_idx];
                    r_alu_r1             <= r_vj[w_issue_idx];
                    r_alu_r2             <= r_vk[w_issue_idx];
                    r_alu_rob_id         <= r_rob[w_issue_idx];
                end else begin
                    r_alu_req <= 1'b0;
                end

                // Dispatch slot is free pre-edge, so it never collides with
                // the wakeup or issue slots above.
                if (bus.disp_valid && !w_full) begin
                    r_valid[w_free_idx]   <= 1'b1;
                    r_type[w_free_idx]    <= bus.disp_type;
                    r_vj[w_free_idx]      <= w_dj_val;
                    r_vk[w_free_idx]      <= w_dk_val;
                    r_qj_busy[w_free_idx] <= w_dj_busy;
                    r_qj[w_free_idx]      <= bus.disp_qj;
                    r_qk_busy[w_free_idx] <= w_dk_busy;
                    r_qk[w_free_idx]      <= bus.disp_qk;
                    r_rob[w_free_idx]     <= bus.disp_rob_id;
                end
            end
        end
    end

    assign bus.full       = w_full;
    assign bus.alu_req    = r_alu_req;
    assign bus.alu_type   = r_alu_type;
    assign bus.alu_r1     = r_alu_r1;
    assign bus.alu_r2     = r_alu_r2;
    assign bus.alu_rob_id = r_alu_rob_id;

endmodule

// File: tb/tb_alu_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_alu_reservation_station
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a slot-array reference model of the reservation station.
// ---------------------------------------------------------------------------
module tb_alu_reservation_station;
    localparam int TW = 4;
    localparam int RW = 4;
    localparam int RS = 8;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic flush;

    int errors;
    int checks;

    alu_reservation_station_if #(.TYPE_BIT(TW), .ROB_INDEX_BIT(RW)) u_if ();

    alu_reservation_station #(
        .RS_SIZE_BIT  (3),
        .TYPE_BIT     (TW),
        .ROB_INDEX_BIT(RW)
    ) u_dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .flush (flush),
        .bus   (u_if)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        bit [TW-1:0] t;
        bit [31:0]   vj;
        bit [31:0]   vk;
        bit          jb;
        bit [RW-1:0] qj;
        bit          kb;
        bit [RW-1:0] qk;
        bit [RW-1:0] rob;
    } ent_t;

    ent_t        m_ent [RS];
    bit          m_req;
    bit [TW-1:0] m_type;
    bit [31:0]   m_r1;
    bit [31:0]   m_r2;
    bit [RW-1:0] m_rob;

    function automatic bit cdb_hit(input bit [RW-1:0] tag);
        return (u_if.alu_cdb_ready && u_if.alu_cdb_rob == tag) ||
               (u_if.lsb_cdb_ready && u_if.lsb_cdb_rob == tag);
    endfunction

    function automatic bit [31:0] cdb_val(input bit [RW-1:0] tag);
        if (u_if.alu_cdb_ready && u_if.alu_cdb_rob == tag) return u_if.alu_cdb_val;
        return u_if.lsb_cdb_val;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < RS; i++) if (!m_ent[i].v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        ent_t old [RS];
        bit   was_full;
        int   iss;
        int   fr;
        if (!rst_in) begin
            for (int i = 0; i < RS; i++) m_ent[i].v = 1'b0;
            m_req = 0; m_type = 0; m_r1 = 0; m_r2 = 0; m_rob = 0;
            return;
        end
        if (!rdy_in) return;
        if (flush) begin
            for (int i = 0; i < RS; i++) m_ent[i].v = 1'b0;
            m_req = 0;
            return;
        end
        old      = m_ent;
        was_full = model_full();
        iss      = -1;
        for (int i = 0; i < RS; i++)
            if (iss < 0 && old[i].v && !old[i].jb && !old[i].kb) iss = i;
        if (iss >= 0) begin
            m_req  = 1;
            m_type = old[iss].t;
            m_r1   = old[iss].vj;
            m_r2   = old[iss].vk;
            m_rob  = old[iss].rob;
            m_ent[iss].v = 1'b0;
        end else begin
            m_req = 0;
        end
        for (int i = 0; i < RS; i++) begin
            if (old[i].v && m_ent[i].jb && cdb_hit(m_ent[i].qj)) begin
                m_ent[i].vj = cdb_val(m_ent[i].qj);
                m_ent[i].jb = 1'b0;
            end
            if (old[i].v && m_ent[i].kb && cdb_hit(m_ent[i].qk)) begin
                m_ent[i].vk = cdb_val(m_ent[i].qk);
                m_ent[i].kb = 1'b0;
            end
        end
        if (u_if.disp_valid && !was_full) begin
            fr = -1;
            for (int i = 0; i < RS; i++) if (fr < 0 && !old[i].v) fr = i;
            m_ent[fr].v   = 1'b1;
            m_ent[fr].t   = u_if.disp_type;
            m_ent[fr].rob = u_if.disp_rob_id;
            m_ent[fr].qj  = u_if.disp_qj;
            m_ent[fr].qk  = u_if.disp_qk;
            m_ent[fr].jb  = u_if.disp_qj_busy && !cdb_hit(u_if.disp_qj);
            m_ent[fr].vj  = (u_if.disp_qj_busy && cdb_hit(u_if.disp_qj)) ? cdb_val(u_if.disp_qj) : u_if.disp_vj;
            m_ent[fr].kb  = u_if.disp_qk_busy && !cdb_hit(u_if.disp_qk);
            m_ent[fr].vk  = (u_if.disp_qk_busy && cdb_hit(u_if.disp_qk)) ? cdb_val(u_if.disp_qk) : u_if.disp_vk;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("req",  32'(u_if.alu_req),    32'(m_req));
        check_eq("full", 32'(u_if.full),       32'(model_full()));
        check_eq("type", 32'(u_if.alu_type),   32'(m_type));
        check_eq("r1",   u_if.alu_r1,          m_r1);
        check_eq("r2",   u_if.alu_r2,          m_r2);
        check_eq("rob",  32'(u_if.alu_rob_id), 32'(m_rob));
    endtask

    // Inputs are changed 1 time unit after the edge, so they are stable for
    // the next edge, and the model sees exactly what the DUT sampled.
    task automatic tick();
        @(posedge clk_in);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic clear_inputs();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush  = 1'b0;
        u_if.disp_valid    = 1'b0;
        u_if.disp_type     = '0;
        u_if.disp_vj       = '0;
        u_if.disp_vk       = '0;
        u_if.disp_qj_busy  = 1'b0;
        u_if.disp_qj       = '0;
        u_if.disp_qk_busy  = 1'b0;
        u_if.disp_qk       = '0;
        u_if.disp_rob_id   = '0;
        u_if.alu_cdb_ready = 1'b0;
        u_if.alu_cdb_rob   = '0;
        u_if.alu_cdb_val   = '0;
        u_if.lsb_cdb_ready = 1'b0;
        u_if.lsb_cdb_rob   = '0;
        u_if.lsb_cdb_val   = '0;
    endtask

    task automatic disp(input bit [TW-1:0] t, input bit [31:0] vj, input bit [31:0] vk,
                        input bit jb, input bit [RW-1:0] qj,
                        input bit kb, input bit [RW-1:0] qk, input bit [RW-1:0] rob);
        u_if.disp_valid   = 1'b1;
        u_if.disp_type    = t;
        u_if.disp_vj      = vj;
        u_if.disp_vk      = vk;
        u_if.disp_qj_busy = jb;
        u_if.disp_qj      = qj;
        u_if.disp_qk_busy = kb;
        u_if.disp_qk      = qk;
        u_if.disp_rob_id  = rob;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < RS; i++) m_ent[i] = '{default: '0};
        m_req = 0; m_type = 0; m_r1 = 0; m_r2 = 0; m_rob = 0;

        // 1: reset
        clear_inputs();
        rst_in = 1'b0;
        tick();
        tick();
        check_eq("rst_req",  32'(u_if.alu_req), 32'd0);
        check_eq("rst_full", 32'(u_if.full),    32'd0);
        check_eq("rst_r1",   u_if.alu_r1,       32'd0);
        clear_inputs();
        tick();

        // 2: ready ADD issues one edge after dispatch
        disp(4'd0, 32'd5, 32'd7, 0, 0, 0, 0, 4'd3);
        tick();
        clear_inputs();
        tick();
        check_eq("add_req", 32'(u_if.alu_req),    32'd1);
        check_eq("add_r1",  u_if.alu_r1,          32'd5);
        check_eq("add_r2",  u_if.alu_r2,          32'd7);
        check_eq("add_rob", 32'(u_if.alu_rob_id), 32'd3);
        tick();
        check_eq("add_req_drop", 32'(u_if.alu_req), 32'd0);

        // 3: SUB waiting on tag 4, woken by ALU CDB
        disp(4'd1, 32'd0, 32'd1, 1, 4'd4, 0, 0, 4'd5);
        tick();
        clear_inputs();
        tick();
        check_eq("sub_wait", 32'(u_if.alu_req), 32'd0);
        u_if.alu_cdb_ready = 1'b1;
        u_if.alu_cdb_rob   = 4'd4;
        u_if.alu_cdb_val   = 32'd10;
        tick();
        clear_inputs();
        tick();
        check_eq("sub_req", 32'(u_if.alu_req), 32'd1);
        check_eq("sub_r1",  u_if.alu_r1,       32'd10);
        check_eq("sub_r2",  u_if.alu_r2,       32'd1);

        // 4: same-cycle forwarding from LSB CDB
        disp(4'd2, 32'd9, 32'd0, 0, 0, 1, 4'd6, 4'd7);
        u_if.lsb_cdb_ready = 1'b1;
        u_if.lsb_cdb_rob   = 4'd6;
        u_if.lsb_cdb_val   = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        tick();
        check_eq("fwd_req", 32'(u_if.alu_req), 32'd1);
        check_eq("fwd_r2",  u_if.alu_r2,       32'hFFFF_FFFF);
        tick();

        // 5: fill all entries, drop the overflow, then drain in order
        for (int k = 0; k < RS; k++) begin
            disp(4'd3, 32'(k), 32'(100 + k), 1, 4'd9, 0, 0, RW'(k));
            tick();
        end
        check_eq("fill_full", 32'(u_if.full), 32'd1);
        disp(4'd3, 32'd0, 32'd0, 1, 4'd9, 0, 0, 4'd15);
        tick();
        clear_inputs();
        check_eq("ovf_full", 32'(u_if.full), 32'd1);
        u_if.alu_cdb_ready = 1'b1;
        u_if.alu_cdb_rob   = 4'd9;
        u_if.alu_cdb_val   = 32'd42;
        tick();
        clear_inputs();
        for (int k = 0; k < RS; k++) begin
            tick();
            check_eq("drain_req", 32'(u_if.alu_req),    32'd1);
            check_eq("drain_rob", 32'(u_if.alu_rob_id), 32'(k));
            check_eq("drain_r1",  u_if.alu_r1,          32'd42);
            if (k == 0) check_eq("drain_full", 32'(u_if.full), 32'd0);
        end
        tick();
        check_eq("drain_end", 32'(u_if.alu_req), 32'd0);

        // 6a: flush with four entries while an issue is in flight
        disp(4'd4, 32'd0, 32'd0, 1, 4'd12, 0, 0, 4'd2); tick();
        disp(4'd4, 32'd0, 32'd0, 1, 4'd12, 0, 0, 4'd3); tick();
        disp(4'd4, 32'd0, 32'd0, 1, 4'd12, 0, 0, 4'd4); tick();
        disp(4'd0, 32'd1, 32'd2, 0, 0, 0, 0, 4'd1);     tick();
        disp(4'd4, 32'd0, 32'd0, 1, 4'd12, 0, 0, 4'd5); tick();
        check_eq("pre_flush_req", 32'(u_if.alu_req), 32'd1);
        flush = 1'b1;
        disp(4'd0, 32'd3, 32'd3, 0, 0, 0, 0, 4'd6);
        tick();
        clear_inputs();
        check_eq("flush_req",  32'(u_if.alu_req), 32'd0);
        check_eq("flush_full", 32'(u_if.full),    32'd0);
        u_if.alu_cdb_ready = 1'b1;
        u_if.alu_cdb_rob   = 4'd12;
        u_if.alu_cdb_val   = 32'd99;
        tick();
        clear_inputs();
        tick();
        check_eq("late_cdb_req", 32'(u_if.alu_req), 32'd0);

        // 6b: rdy_in low freezes an issued op and ignores dispatch
        disp(4'd5, 32'd77, 32'd1, 0, 0, 0, 0, 4'd6); tick();
        disp(4'd5, 32'd88, 32'd2, 0, 0, 0, 0, 4'd7); tick();
        rdy_in = 1'b0;
        disp(4'd5, 32'd55, 32'd3, 0, 0, 0, 0, 4'd8);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("frz_req", 32'(u_if.alu_req),    32'd1);
            check_eq("frz_rob", 32'(u_if.alu_rob_id), 32'd6);
            check_eq("frz_r1",  u_if.alu_r1,          32'd77);
        end
        clear_inputs();
        tick();
        check_eq("thaw_rob", 32'(u_if.alu_rob_id), 32'd7);
        tick();
        check_eq("thaw_end", 32'(u_if.alu_req), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            rst_in = ($urandom_range(0, 199) != 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) < 60)
                disp(TW'($urandom_range(0, 15)), $urandom(), $urandom(),
                     ($urandom_range(0, 9) < 4), RW'($urandom_range(0, 7)),
                     ($urandom_range(0, 9) < 4), RW'($urandom_range(0, 7)),
                     RW'($urandom_range(0, 15)));
            u_if.alu_cdb_ready = ($urandom_range(0, 9) < 4);
            u_if.alu_cdb_rob   = RW'($urandom_range(0, 7));
            u_if.alu_cdb_val   = $urandom();
            u_if.lsb_cdb_ready = ($urandom_range(0, 9) < 4);
            u_if.lsb_cdb_rob   = RW'($urandom_range(0, 7));
            u_if.lsb_cdb_val   = $urandom();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
